// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch responder: assembles a 32-bit little-endian word from four byte reads of a synchronous byte memory.
// Latency: 6 cycles on a miss, 1 cycle on a hit in the one-entry buffer; flush aborts a fetch in RD/WAIT without a ready pulse.
module inst_fetch_bridge #(
  parameter int ADDR_WIDTH = 17,
  parameter bit BUF_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  input  logic                  flush,
  output logic [31:0]           if_inst,
  output logic                  if_ready,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [1:0]            cnt;
  logic [23:0]           lanes;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [31:0]           buf_data;
  logic                  buf_valid;

  logic [ADDR_WIDTH-1:0] base;
  logic                  hit;
  logic                  unused_addr_bits;

  assign base = {if_addr[ADDR_WIDTH-1:2], 2'b00};
  assign hit  = BUF_EN && buf_valid && (base == buf_addr);
  assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH], if_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      lanes     <= 24'd0;
      base_addr <= '0;
      buf_addr  <= '0;
      buf_data  <= 32'd0;
      buf_valid <= 1'b0;
      if_inst   <= 32'd0;
      if_ready  <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (if_req && hit) begin
            if_inst  <= buf_data;
            if_ready <= 1'b1;
            state    <= S_DONE;
          end else if (if_req) begin
            mem_re    <= 1'b1;
            mem_addr  <= base;
            base_addr <= base;
            cnt       <= 2'd0;
            state     <= S_RD;
          end
        end
        S_RD: begin
          if (flush) begin
            mem_re <= 1'b0;
            state  <= S_IDLE;
          end else begin
            mem_addr <= mem_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            cnt      <= cnt + 2'd1;
            // Byte for the address issued last cycle arrives now; lane 3 lands in WAIT.
            case (cnt)
              2'd1:    lanes[7:0]   <= mem_rdata;
              2'd2:    lanes[15:8]  <= mem_rdata;
              2'd3:    lanes[23:16] <= mem_rdata;
              default: ;
            endcase
            if (cnt == 2'd3) begin
              mem_re <= 1'b0;
              state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (flush) begin
            mem_re <= 1'b0;
            state  <= S_IDLE;
          end else begin
            if_inst   <= {mem_rdata, lanes};
            if_ready  <= 1'b1;
            buf_addr  <= base_addr;
            buf_data  <= {mem_rdata, lanes};
            buf_valid <= BUF_EN;
            state     <= S_DONE;
          end
        end
        default: begin
          if_ready <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: a buffered and an unbuffered instance, each backed by a byte memory model.
module tb_inst_fetch_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        flush;
  logic        sel;

  logic [31:0] inst_a, inst_b;
  logic        ready_a, ready_b;
  logic        re_a, re_b;
  logic [16:0] maddr_a, maddr_b;
  logic [7:0]  rdata_a, rdata_b;

  logic [7:0]  mem [0:131071];

  logic [31:0] o_inst;
  logic        o_ready;
  logic        o_re;
  logic [16:0] o_maddr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch_bridge #(.ADDR_WIDTH(17), .BUF_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .if_req(req & ~sel), .if_addr(addr), .flush(flush),
    .if_inst(inst_a), .if_ready(ready_a), .mem_re(re_a), .mem_addr(maddr_a), .mem_rdata(rdata_a)
  );

  inst_fetch_bridge #(.ADDR_WIDTH(17), .BUF_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .if_req(req & sel), .if_addr(addr), .flush(flush),
    .if_inst(inst_b), .if_ready(ready_b), .mem_re(re_b), .mem_addr(maddr_b), .mem_rdata(rdata_b)
  );

  always @(posedge clk) begin
    if (re_a) rdata_a <= mem[maddr_a];
    if (re_b) rdata_b <= mem[maddr_b];
  end

  assign o_inst  = sel ? inst_b  : inst_a;
  assign o_ready = sel ? ready_b : ready_a;
  assign o_re    = sel ? re_b    : re_a;
  assign o_maddr = sel ? maddr_b : maddr_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues a fetch (or continues one already driven) and measures it from the accept cycle.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_inst,
                       input int exp_lat, input int exp_re, input logic [16:0] exp_first,
                       input bit drive);
    int lat = 0;
    int nre = 0;
    logic [16:0] first = '0;
    logic [16:0] last  = '0;
    logic seen = 1'b0;
    logic [31:0] got = '0;
    if (drive) @(negedge clk);
    req  = 1'b1;
    addr = a;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (o_re) begin
        if (nre == 0) first = o_maddr;
        last = o_maddr;
        nre++;
      end
      if (o_ready) begin
        seen = 1'b1;
        got  = o_inst;
      end
    end
    req = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_inst"}, got, exp_inst);
    chk({tag, "_re_cycles"}, nre, exp_re);
    chk({tag, "_first_addr"}, {15'd0, first}, {15'd0, exp_first});
    chk({tag, "_last_addr"}, {15'd0, last}, (exp_re > 0) ? {15'd0, exp_first + 17'd3} : 32'd0);
    @(negedge clk);
    chk({tag, "_ready_one_cycle"}, {31'd0, o_ready}, 32'd0);
  endtask

  initial begin
    int stray;
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[17'h00100] = 8'h13; mem[17'h00101] = 8'h00; mem[17'h00102] = 8'h50; mem[17'h00103] = 8'h00;
    mem[17'h00200] = 8'h93; mem[17'h00201] = 8'h80; mem[17'h00202] = 8'h10; mem[17'h00203] = 8'h00;
    mem[17'h00004] = 8'h11; mem[17'h00005] = 8'h22; mem[17'h00006] = 8'h33; mem[17'h00007] = 8'h44;
    mem[17'h1FFFC] = 8'hEF; mem[17'h1FFFD] = 8'hBE; mem[17'h1FFFE] = 8'hAD; mem[17'h1FFFF] = 8'hDE;

    sel   = 1'b0;
    flush = 1'b0;
    rst   = 1'b0;
    req   = 1'b1;
    addr  = 32'h100;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, o_ready}, 32'd0);
      chk("rst_inst", o_inst, 32'd0);
      chk("rst_re", {31'd0, o_re}, 32'd0);
      chk("rst_maddr", {15'd0, o_maddr}, 32'd0);
    end
    rst = 1'b1;
    req = 1'b0;

    fetch("miss100", 32'h100, 32'h00500013, 6, 4, 17'h100, 1'b1);
    fetch("hit100", 32'h100, 32'h00500013, 1, 0, 17'h0, 1'b1);
    fetch("hit102", 32'h102, 32'h00500013, 1, 0, 17'h0, 1'b1);

    // Flush mid-fetch of 0x200
    @(negedge clk);
    req  = 1'b1;
    addr = 32'h200;
    repeat (3) @(negedge clk);
    chk("flush_re_before", {31'd0, o_re}, 32'd1);
    flush = 1'b1;
    req   = 1'b0;
    @(negedge clk);
    chk("flush_re_after", {31'd0, o_re}, 32'd0);
    flush = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_ready || o_re) stray++;
    end
    chk("flush_no_activity", stray, 0);
    fetch("hit100_after_flush", 32'h100, 32'h00500013, 1, 0, 17'h0, 1'b1);
    fetch("miss200", 32'h200, 32'h00108093, 6, 4, 17'h200, 1'b1);

    // Flush and request together in IDLE; accepted only once flush drops
    @(negedge clk);
    flush = 1'b1;
    req   = 1'b1;
    addr  = 32'hFFFE_0004;
    @(negedge clk);
    chk("flush_req_re", {31'd0, o_re}, 32'd0);
    chk("flush_req_ready", {31'd0, o_ready}, 32'd0);
    flush = 1'b0;
    fetch("trunc", 32'hFFFE_0004, 32'h44332211, 6, 4, 17'h00004, 1'b0);

    fetch("wrap", 32'h0003_FFFE, 32'hDEADBEEF, 6, 4, 17'h1FFFC, 1'b1);

    // Reset mid-fetch clears the buffer
    @(negedge clk);
    req  = 1'b1;
    addr = 32'h100;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    chk("midrst_re", {31'd0, o_re}, 32'd0);
    chk("midrst_ready", {31'd0, o_ready}, 32'd0);
    rst = 1'b1;
    fetch("after_rst_miss", 32'h1FFFC, 32'hDEADBEEF, 6, 4, 17'h1FFFC, 1'b1);

    // Unbuffered instance: repeated fetches always miss
    sel = 1'b1;
    fetch("nobuf_first", 32'h100, 32'h00500013, 6, 4, 17'h100, 1'b1);
    fetch("nobuf_repeat", 32'h102, 32'h00500013, 6, 4, 17'h100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_bridge.md
# inst_fetch_bridge

Sequential instruction-fetch responder that serves the CPU's fetch port (`rom_ce`/`rom_addr` → instruction) from an external byte-wide synchronous memory. It sits between `riscv_cpu` and the board-level byte memory in the SOPC, replacing the combinational instruction ROM. Each 32-bit instruction is assembled from four little-endian byte reads. A one-entry instruction buffer lets repeated fetches of the same word return without a memory access.

## Interface
- `ADDR_WIDTH`, default 17: byte-address width of external memory.
- `BUF_EN`, default 1: 1 enables the one-entry instruction buffer; 0 makes every request a miss.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`.
- `if_req`  in  1  CPU fetch request; held high until `if_ready`.
- `if_addr`  in  32  CPU fetch byte address; stable while `if_req` is high.
- `flush`  in  1  abort any in-flight fetch (branch/redirect).
- `if_inst`  out  32  fetched instruction; valid only while `if_ready` is high.
- `if_ready`  out  1  one-cycle completion strobe.
- `mem_re`  out  1  external memory read enable.
- `mem_addr`  out  ADDR_WIDTH  external memory byte address.
- `mem_rdata`  in  8  byte returned exactly one cycle after the cycle `mem_re` is high.

## Operation
- All outputs are registered. On reset: `if_ready`=0, `if_inst`=0, `mem_re`=0, `mem_addr`=0, `buf_valid`=0, state=IDLE, byte counter=0.
- Base address = `{if_addr[ADDR_WIDTH-1:2], 2'b00}`.
  - `if_addr[1:0]` is ignored.
  - `if_addr[31:ADDR_WIDTH]` is ignored.
  - The base address is latched at accept.
- FSM states: IDLE, RD, WAIT, DONE.
- **IDLE**
  - If `flush`=1, stay in IDLE and accept nothing. `flush` beats `if_req` when both are high.
  - Else if `if_req`=1 and `BUF_EN`=1 and `buf_valid`=1 and base equals `buf_addr` (hit):
    - `if_inst` ← `buf_data`, `if_ready` ← 1.
    - Go to DONE.
  - Else if `if_req`=1 (miss):
    - `mem_re` ← 1, `mem_addr` ← base, counter ← 0.
    - Go to RD.
- **RD** (4 cycles)
  - Each cycle: `mem_addr` ← `mem_addr`+1, counter increments.
  - While counter ≥1, the byte on `mem_rdata` is stored into lane (counter−1).
  - After the 4th issue cycle: `mem_re` ← 0, go to WAIT.
- **WAIT** (1 cycle)
  - Capture lane 3.
  - At the edge: `if_inst` ← `{b3,b2,b1,b0}`, `if_ready` ← 1.
  - Buffer update at the same edge: `buf_addr` ← base, `buf_data` ← same word, `buf_valid` ← `BUF_EN`.
  - Go to DONE.
- **DONE** (1 cycle)
  - `if_ready`=1 for exactly this cycle; `flush` does not cancel it.
  - At the edge: `if_ready` ← 0, go to IDLE.
  - A new request is evaluated only in IDLE.
- **`flush`=1 in RD or WAIT**
  - At the edge: state ← IDLE, `mem_re` ← 0.
  - No `if_ready` pulse; buffer unchanged.
  - Bytes returning after the abort are ignored.
- **Wrap-around:** base is word-aligned, so base+3 never crosses the `2^ADDR_WIDTH` boundary. `mem_addr` arithmetic is modulo `2^ADDR_WIDTH`.
- **Reset mid-fetch** (`rst`=0 in any state): next edge returns to reset values. `buf_valid` is cleared.
- Byte lane order is little-endian: the byte at base+0 becomes `if_inst[7:0]`.

## Timing
- `if_req` first high in IDLE at cycle T, with no flush:
  - Miss: `mem_re`=1 in cycles T+1..T+4 with `mem_addr` = base..base+3. Bytes arrive T+2..T+5. `if_ready`=1 in T+6 only. Miss latency is 6 cycles.
  - Hit: `if_ready`=1 in T+1. Hit latency is 1 cycle.
- Back-to-back: with `if_req` held high across DONE, the next accept is evaluated in IDLE at T+7 for a miss (T+2 for a hit). Throughput is 1 instruction per 7 cycles (miss) or 2 cycles (hit).
- `flush` sampled high at edge E: `mem_re` is 0 from E+1 onward.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `if_req`=1 → all outputs stay 0, `mem_re` never asserts. Release → miss fetch starts on the next IDLE cycle.
- **Miss fetch:** memory bytes at 0x100..0x103 = 13,00,50,00; `if_req` at T with `if_addr`=0x100 → `mem_addr` 0x100..0x103 in T+1..T+4, `if_ready` only at T+6, `if_inst`=0x00500013.
- **Buffer hit:** repeat the fetch of 0x100, then 0x102 (low bits ignored) → each gives `if_ready` one cycle after accept, `if_inst`=0x00500013, `mem_re` stays 0. With `BUF_EN`=0 → both take 6 cycles.
- **Flush mid-fetch:** `if_req` 0x200 at T, `flush`=1 at T+3 → `mem_re`=0 from T+4, no `if_ready`. A following fetch of 0x200 is a miss (buffer still holds 0x100).
- **Flush vs request:** `flush`=1 and `if_req`=1 together in IDLE → no accept that cycle; accept on the next cycle once `flush`=0.
- **Address truncation:** `if_addr`=0xFFFE_0004 with `ADDR_WIDTH`=17 → `mem_addr` = 0x00004..0x00007; wrap at 0x1FFFC yields 0x1FFFC..0x1FFFF.
